// File: rtl/answer_judge.sv
// Answer judge: decodes the three committed answer codes to prime factors, multiplies
// them over two cycles and compares the product against the BCD question.
module answer_judge (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  STATE,
    input  logic        DEC,
    input  logic [3:0]  COUNT1_OUT,
    input  logic [3:0]  COUNT2_OUT,
    input  logic [3:0]  COUNT3_OUT,
    input  logic [11:0] QUESTION_D,
    output logic [1:0]  RESULT,
    output logic        RES_VALID,
    output logic        BUSY,
    output logic [13:0] PRODUCT
);
    localparam logic [3:0] ST_INPUT    = 4'b0100;
    localparam logic [3:0] ST_QUESTION = 4'b0011;

    typedef enum logic [2:0] {IDLE, ARM, MUL1, MUL2, CMP} fsm_t;
    fsm_t fsm_state;

    logic [3:0]  code1, code2, code3;
    logic [11:0] q_bcd;
    logic [9:0]  q_bin;
    logic [13:0] prod;
    logic [4:0]  f1, f2, f3;
    logic        end_state, bad_code, bad_q;
    logic [1:0]  verdict;
    logic [13:0] prod_next;

    // Invalid codes decode to 0; the verdict is forced to invalid for them anyway.
    function automatic logic [4:0] decode(input logic [3:0] c);
        case (c)
            4'd0:    decode = 5'd1;
            4'd1:    decode = 5'd2;
            4'd2:    decode = 5'd3;
            4'd3:    decode = 5'd5;
            4'd4:    decode = 5'd7;
            4'd5:    decode = 5'd11;
            4'd6:    decode = 5'd13;
            4'd7:    decode = 5'd17;
            4'd8:    decode = 5'd19;
            4'd9:    decode = 5'd23;
            default: decode = 5'd0;
        endcase
    endfunction

    always_comb begin
        f1 = decode(code1);
        f2 = decode(code2);
        f3 = decode(code3);
        end_state = STATE inside {4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
        bad_code = (code1 > 4'd9) || (code2 > 4'd9) || (code3 > 4'd9) ||
                   ((code1 == 4'd0) && (code2 == 4'd0) && (code3 == 4'd0));
        bad_q = (q_bcd[11:8] > 4'd9) || (q_bcd[7:4] > 4'd9) || (q_bcd[3:0] > 4'd9);
        prod_next = prod * {9'd0, f3};
        if (bad_code || bad_q)
            verdict = 2'b11;
        else if (prod == {4'd0, q_bin})
            verdict = 2'b01;
        else
            verdict = 2'b10;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fsm_state <= IDLE;
            RESULT    <= 2'b00;
            RES_VALID <= 1'b0;
            BUSY      <= 1'b0;
            PRODUCT   <= 14'd0;
            code1     <= 4'd0;
            code2     <= 4'd0;
            code3     <= 4'd0;
            q_bcd     <= 12'd0;
            q_bin     <= 10'd0;
            prod      <= 14'd0;
        end else begin
            RES_VALID <= 1'b0;
            if (STATE == ST_QUESTION)
                RESULT <= 2'b00;
            if (BUSY && end_state) begin
                fsm_state <= IDLE;
                BUSY      <= 1'b0;
            end else begin
                case (fsm_state)
                    IDLE: begin
                        if (DEC && (STATE == ST_INPUT)) begin
                            fsm_state <= ARM;
                            BUSY      <= 1'b1;
                        end
                    end
                    // The input block updates the codes on the edge that samples DEC,
                    // so they are only stable one cycle later.
                    ARM: begin
                        code1     <= COUNT1_OUT;
                        code2     <= COUNT2_OUT;
                        code3     <= COUNT3_OUT;
                        q_bcd     <= QUESTION_D;
                        fsm_state <= MUL1;
                    end
                    MUL1: begin
                        prod      <= {9'd0, f1} * {9'd0, f2};
                        q_bin     <= {6'd0, q_bcd[11:8]} * 10'd100 +
                                     {6'd0, q_bcd[7:4]} * 10'd10 + {6'd0, q_bcd[3:0]};
                        fsm_state <= MUL2;
                    end
                    MUL2: begin
                        prod      <= prod_next;
                        PRODUCT   <= prod_next;
                        fsm_state <= CMP;
                    end
                    CMP: begin
                        if (STATE != ST_QUESTION)
                            RESULT <= verdict;
                        RES_VALID <= 1'b1;
                        BUSY      <= 1'b0;
                        fsm_state <= IDLE;
                    end
                    default: begin
                        fsm_state <= IDLE;
                        BUSY      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_answer_judge.sv
// Directed bench for answer_judge: expected verdicts are queued when a judgement is
// started and popped when RES_VALID appears.
module tb_answer_judge;
    logic        clk;
    logic        rst_n;
    logic [3:0]  state;
    logic        dec;
    logic [3:0]  c1, c2, c3;
    logic [11:0] q_d;
    logic [1:0]  result;
    logic        res_valid;
    logic        busy;
    logic [13:0] product;

    logic [1:0] exp_q[$];
    int checks;
    int errors;

    answer_judge dut (
        .CLK(clk), .RST(rst_n), .STATE(state), .DEC(dec),
        .COUNT1_OUT(c1), .COUNT2_OUT(c2), .COUNT3_OUT(c3), .QUESTION_D(q_d),
        .RESULT(result), .RES_VALID(res_valid), .BUSY(busy), .PRODUCT(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_valid"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, {30'd0, result}, {30'd0, e});
        end
    endtask

    // One full judgement; prod < 0 skips the product check, perturb changes inputs mid-run.
    task automatic judge(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [11:0] q, input logic [1:0] res,
                         input int prod, input bit perturb);
        int cyc;
        @(negedge clk);
        c1 = a; c2 = b; c3 = c; q_d = q; dec = 1'b1;
        exp_q.push_back(res);
        @(posedge clk);
        #1;
        check({tag, "_busy_arm"}, {31'd0, busy}, 1);
        dec = 1'b0;
        cyc = 0;
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (perturb && cyc == 2) begin
                c1 = 4'd0; c2 = 4'd0; c3 = 4'd0; q_d = 12'h999;
            end
            if (res_valid) break;
        end
        check({tag, "_latency"}, cyc, 5);
        if (res_valid) pop_check(tag);
        if (prod >= 0) check({tag, "_product"}, {18'd0, product}, prod);
        check({tag, "_busy_done"}, {31'd0, busy}, 0);
        @(negedge clk);
        check({tag, "_valid_pulse"}, {31'd0, res_valid}, 0);
    endtask

    initial begin
        int pulses;
        logic [1:0] held;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        state = 4'b0100;
        dec = 1'b0;
        c1 = 4'd0; c2 = 4'd0; c3 = 4'd0; q_d = 12'h000;
        repeat (3) @(negedge clk);
        check("reset_result", {30'd0, result}, 0);
        check("reset_valid", {31'd0, res_valid}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_product", {18'd0, product}, 0);
        rst_n = 1'b1;

        judge("three_factors", 4'd2, 4'd3, 4'd4, 12'h105, 2'b01, 105, 1'b0);
        judge("blank_ok", 4'd1, 4'd2, 4'd3, 12'h030, 2'b01, 30, 1'b0);
        judge("blank_wrong", 4'd1, 4'd2, 4'd0, 12'h030, 2'b10, 6, 1'b0);
        judge("all_zero", 4'd0, 4'd0, 4'd0, 12'h001, 2'b11, 1, 1'b0);
        judge("code_ten", 4'd10, 4'd1, 4'd1, 12'h004, 2'b11, -1, 1'b0);
        judge("non_bcd_q", 4'd2, 4'd3, 4'd4, 12'h0A5, 2'b11, 105, 1'b0);
        judge("single_slot", 4'd0, 4'd0, 4'd9, 12'h023, 2'b01, 23, 1'b0);
        judge("max_product", 4'd9, 4'd9, 4'd9, 12'h999, 2'b10, 12167, 1'b0);
        judge("frozen_inputs", 4'd2, 4'd3, 4'd4, 12'h105, 2'b01, 105, 1'b1);

        // DEC held for 8 edges: one verdict inside the hold, one re-trigger from edge N+5.
        @(negedge clk);
        c1 = 4'd1; c2 = 4'd1; c3 = 4'd2; q_d = 12'h012;
        dec = 1'b1;
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid) begin pulses++; pop_check("held_first"); end
        end
        dec = 1'b0;
        check("held_pulses_in_hold", pulses, 1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) begin pulses++; pop_check("held_retrigger"); end
        end
        check("held_pulses_after", pulses, 1);

        judge("before_abort", 4'd1, 4'd2, 4'd0, 12'h030, 2'b10, 6, 1'b0);
        held = 2'b10;
        // Abort: end state sampled at edge N+2.
        @(negedge clk);
        c1 = 4'd2; c2 = 4'd3; c3 = 4'd4; q_d = 12'h105; dec = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dec = 1'b0;
        @(negedge clk);
        state = 4'b1001;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 0);
        state = 4'b0100;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (res_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        check("abort_result_kept", {30'd0, result}, {30'd0, held});

        @(negedge clk);
        state = 4'b0011;
        @(negedge clk);
        check("question_clear", {30'd0, result}, 0);
        state = 4'b0100;

        // Asynchronous reset shortly after edge N+3, checked before any further edge.
        judge("before_reset", 4'd2, 4'd3, 4'd4, 12'h105, 2'b01, 105, 1'b0);
        @(negedge clk);
        c1 = 4'd3; c2 = 4'd3; c3 = 4'd0; q_d = 12'h025; dec = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dec = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_result", {30'd0, result}, 0);
        check("areset_busy", {31'd0, busy}, 0);
        check("areset_product", {18'd0, product}, 0);
        check("areset_valid", {31'd0, res_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        judge("after_reset", 4'd3, 4'd3, 4'd0, 12'h025, 2'b01, 25, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
